// File: rtl/dmux_pkg.sv
// Shared constants and helpers for the registered N-way demultiplexer.
package dmux_pkg;

    localparam int DMUX_WIDTH    = 16;
    localparam int DMUX_CHANNELS = 8;

    // True when a select value addresses an existing channel.
    function automatic logic sel_in_range(input int unsigned sel, input int unsigned channels);
        return sel < channels;
    endfunction

endpackage

// File: rtl/dmux_slot.sv
// One-entry holding register for a single output channel.
// An invalid slot always presents zero data.
module dmux_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             free
);

    // Slot can take a word when empty or when its word leaves this cycle.
    assign free = !valid || out_ready;

    // Load has priority over drain so a simultaneous drain+load keeps valid high.
    always_ff @(posedge clk) begin
        // NOTE: the data register is reset as well as valid, because the output must read zero whenever the slot is empty.
        if (rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (valid && out_ready) begin
            valid <= 1'b0;
            dout  <= '0;
        end
    end

endmodule

// File: rtl/dmux_nway_reg.sv
// Registered N-way demultiplexer with per-channel valid/ready holding slots,
// unicast or broadcast routing and a sticky out-of-range select flag.
module dmux_nway_reg
    import dmux_pkg::*;
#(
    parameter int WIDTH    = DMUX_WIDTH,
    parameter int CHANNELS = DMUX_CHANNELS,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          X,
    input  logic [SEL_W-1:0]          s,
    input  logic                      bcast,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] OUT,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic                      sel_err
);

    logic [CHANNELS-1:0] free;
    logic [CHANNELS-1:0] load;
    logic                sel_ok;
    logic                accept;

    assign sel_ok = sel_in_range(32'(s), CHANNELS);
    assign accept = in_valid && in_ready;

    // Ready decision: broadcast needs every slot, unicast needs its target, bad selects always drain.
    always_comb begin
        // NOTE: default assignment first so no path through this block leaves in_ready unassigned (no latch).
        in_ready = 1'b0;
        if (rst) begin
            in_ready = 1'b0;
        end else if (bcast) begin
            in_ready = &free;
        end else if (sel_ok) begin
            in_ready = free[s];
        end else begin
            in_ready = 1'b1;
        end
    end

    // Sticky error: any accepted unicast word with a select beyond the last channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (accept && !bcast && !sel_ok) begin
            sel_err <= 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_slot
        assign load[i] = accept && (bcast || (sel_ok && (s == SEL_W'(i))));

        dmux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[i]),
            .din       (X),
            .out_ready (out_ready[i]),
            .dout      (OUT[i*WIDTH +: WIDTH]),
            .valid     (out_valid[i]),
            .free      (free[i])
        );
    end

endmodule

// File: tb/tb_dmux_nway_reg.sv
// Self-checking bench: directed scenarios on 8- and 6-channel instances,
// then a randomised scoreboard run on an 8-bit, 3-channel instance.
module tb_dmux_nway_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- 8-channel, 16-bit instance ----------------
    logic         rst8, bc8, iv8, ir8, se8;
    logic [15:0]  x8;
    logic [2:0]   s8;
    logic [127:0] out8;
    logic [7:0]   ov8, or8;

    dmux_nway_reg #(.WIDTH(16), .CHANNELS(8)) u_dut8 (
        .clk(clk), .rst(rst8), .X(x8), .s(s8), .bcast(bc8), .in_valid(iv8),
        .in_ready(ir8), .OUT(out8), .out_valid(ov8), .out_ready(or8), .sel_err(se8)
    );

    // ---------------- 6-channel, 16-bit instance ----------------
    logic        rst6, bc6, iv6, ir6, se6;
    logic [15:0] x6;
    logic [2:0]  s6;
    logic [95:0] out6;
    logic [5:0]  ov6, or6;

    dmux_nway_reg #(.WIDTH(16), .CHANNELS(6)) u_dut6 (
        .clk(clk), .rst(rst6), .X(x6), .s(s6), .bcast(bc6), .in_valid(iv6),
        .in_ready(ir6), .OUT(out6), .out_valid(ov6), .out_ready(or6), .sel_err(se6)
    );

    // ---------------- 3-channel, 8-bit instance ----------------
    logic        rst3, bc3, iv3, ir3, se3;
    logic [7:0]  x3;
    logic [1:0]  s3;
    logic [23:0] out3;
    logic [2:0]  ov3, or3;

    dmux_nway_reg #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
        .clk(clk), .rst(rst3), .X(x3), .s(s3), .bcast(bc3), .in_valid(iv3),
        .in_ready(ir3), .OUT(out3), .out_valid(ov3), .out_ready(or3), .sel_err(se3)
    );

    // Reference model for the random run: one queue of pending words per channel.
    logic [7:0] model_q [3][$];
    logic       model_err;
    int         n_accepted, n_delivered;

    logic [127:0] exp8;

    initial begin
        rst8 = 1'b1; bc8 = 1'b0; iv8 = 1'b0; x8 = '0; s8 = '0; or8 = '0;
        rst6 = 1'b1; bc6 = 1'b0; iv6 = 1'b0; x6 = '0; s6 = '0; or6 = '0;
        rst3 = 1'b1; bc3 = 1'b0; iv3 = 1'b0; x3 = '0; s3 = '0; or3 = '0;

        // ---- Reset then unicast ----
        iv8 = 1'b1; x8 = 16'hBEEF; s8 = 3'd5;
        tick();
        check("rst_in_ready", ir8, 0);
        tick();
        check("rst_out_valid", ov8, 0);
        check("rst_out", out8, 0);
        check("rst_sel_err", se8, 0);
        check("rst_in_ready2", ir8, 0);
        rst8 = 1'b0;
        #1;
        check("uni_in_ready", ir8, 1);
        tick();
        x8 = 16'h1111;
        #1;
        exp8 = '0;
        exp8[5*16 +: 16] = 16'hBEEF;
        check("uni_out_valid", ov8, 8'b0010_0000);
        check("uni_out", out8, exp8);
        check("uni_second_blocked", ir8, 0);
        tick();
        check("uni_held_valid", ov8, 8'b0010_0000);
        check("uni_held_out", out8, exp8);

        // ---- Backpressure and pass-through on channel 2 ----
        s8 = 3'd2; x8 = 16'h00AA;
        tick();
        check("pt_fill_valid", ov8, 8'b0010_0100);
        or8 = 8'b0000_0100; x8 = 16'h0001;
        #1;
        check("pt_ready_1", ir8, 1);
        tick();
        x8 = 16'h0002;
        #1;
        check("pt_slice_1", out8[2*16 +: 16], 16'h0001);
        check("pt_valid_1", ov8[2], 1);
        check("pt_ready_2", ir8, 1);
        tick();
        iv8 = 1'b0;
        check("pt_slice_2", out8[2*16 +: 16], 16'h0002);
        check("pt_valid_2", ov8[2], 1);
        tick();
        check("pt_drained_valid", ov8, 8'b0010_0000);
        check("pt_drained_slice", out8[2*16 +: 16], 0);

        // drain everything
        or8 = '1;
        tick();
        check("drain_all_valid", ov8, 0);
        check("drain_all_out", out8, 0);
        or8 = '0;

        // ---- Broadcast blocking ----
        iv8 = 1'b1; s8 = 3'd7; x8 = 16'h00CC;
        tick();
        bc8 = 1'b1; x8 = 16'h1234;
        #1;
        check("bc_blocked_ready", ir8, 0);
        tick();
        check("bc_blocked_valid", ov8, 8'h80);
        check("bc_blocked_slice7", out8[7*16 +: 16], 16'h00CC);
        or8[7] = 1'b1;
        #1;
        check("bc_ready", ir8, 1);
        tick();
        iv8 = 1'b0; bc8 = 1'b0; or8 = '0;
        check("bc_all_valid", ov8, 8'hFF);
        check("bc_all_out", out8, {8{16'h1234}});

        // ---- Reset mid-operation ----
        or8 = '1;
        tick();
        or8 = '0;
        iv8 = 1'b1; s8 = 3'd0; x8 = 16'hA0A0;
        tick();
        s8 = 3'd3; x8 = 16'hA3A3;
        tick();
        check("mid_pre_valid", ov8, 8'b0000_1001);
        s8 = 3'd1; x8 = 16'hA1A1; rst8 = 1'b1;
        tick();
        rst8 = 1'b0; iv8 = 1'b0;
        #1;
        check("mid_valid", ov8, 0);
        check("mid_out", out8, 0);
        check("mid_sel_err", se8, 0);

        // ---- Out-of-range select on the 6-channel instance ----
        rst6 = 1'b0;
        iv6 = 1'b1; s6 = 3'd7; x6 = 16'hDEAD;
        #1;
        check("oor_ready", ir6, 1);
        tick();
        s6 = 3'd6;
        #1;
        check("oor_sel_err", se6, 1);
        check("oor_no_valid", ov6, 0);
        check("oor6_ready", ir6, 1);
        tick();
        s6 = 3'd5; x6 = 16'h5555;
        #1;
        check("oor6_no_valid", ov6, 0);
        check("last_ch_ready", ir6, 1);
        tick();
        iv6 = 1'b0;
        check("oor_sticky", se6, 1);
        check("last_ch_valid", ov6, 6'b10_0000);
        check("last_ch_out", out6[5*16 +: 16], 16'h5555);
        tick();
        check("oor_sticky2", se6, 1);
        rst6 = 1'b1; iv6 = 1'b1; s6 = 3'd7;
        tick();
        rst6 = 1'b0; iv6 = 1'b0;
        #1;
        check("oor_rst_err", se6, 0);
        check("oor_rst_valid", ov6, 0);
        check("oor_rst_out", out6, 0);

        // ---- Randomised scoreboard on the 3-channel instance ----
        rst3 = 1'b0;
        model_err = 1'b0;
        n_accepted = 0;
        n_delivered = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic       free_c [3];
            logic       all_free;
            logic       exp_ready;
            logic [7:0] exp_slice;

            // a stalled producer holds its word; otherwise draw a fresh one
            if (!(iv3 && !ir3)) begin
                iv3 = ($urandom_range(0, 3) != 0);
                x3  = 8'($urandom);
                s3  = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                bc3 = ($urandom_range(0, 7) == 0);
            end
            or3 = 3'($urandom);
            #1;

            all_free = 1'b1;
            for (int c = 0; c < 3; c++) begin
                free_c[c] = (model_q[c].size() == 0) || or3[c];
                all_free  = all_free && free_c[c];
                exp_slice = (model_q[c].size() != 0) ? model_q[c][0] : 8'h00;
                check("rnd_valid", ov3[c], model_q[c].size() != 0);
                check("rnd_slice", out3[c*8 +: 8], exp_slice);
            end
            if (bc3)        exp_ready = all_free;
            else if (s3 < 3) exp_ready = free_c[s3];
            else            exp_ready = 1'b1;
            check("rnd_ready", ir3, exp_ready);
            check("rnd_sel_err", se3, model_err);

            // delivery then acceptance, as seen at the coming edge
            for (int c = 0; c < 3; c++) begin
                if (model_q[c].size() != 0 && or3[c]) begin
                    void'(model_q[c].pop_front());
                    n_delivered++;
                end
            end
            if (iv3 && exp_ready) begin
                if (bc3) begin
                    for (int c = 0; c < 3; c++) begin
                        model_q[c].push_back(x3);
                        n_accepted++;
                    end
                end else if (s3 < 3) begin
                    model_q[s3].push_back(x3);
                    n_accepted++;
                end else begin
                    model_err = 1'b1;
                end
            end
            tick();
        end

        // words still held plus words delivered must equal words accepted
        check("rnd_conservation", n_delivered + model_q[0].size() + model_q[1].size() + model_q[2].size(), n_accepted);
        check("rnd_final_valid", ov3, {model_q[2].size() != 0, model_q[1].size() != 0, model_q[0].size() != 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
